// File: rtl/tiny_cpu_pkg.sv
// Shared opcode constants and FSM state encoding for the tiny multicycle CPU.
package tiny_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_MOV = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_OUT = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

endpackage

// File: rtl/tiny_alu.sv
// Combinational ALU: result, carry/borrow and zero for the arithmetic/logic opcodes.
module tiny_alu
  import tiny_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  // Compute the result and carry; the extra top bit of the sum/difference is carry/borrow
  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: {c, y} = {1'b0, a} - {1'b0, b};
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      OP_SHR: begin
        y = {1'b0, a[DATA_W-1:1]};
        c = a[0];
      end
      default: begin
        y = '0;
        c = 1'b0;
      end
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/tiny_cpu_mc.sv
// Four-state multicycle CPU: IDLE -> DECODE -> EXEC -> WB, one instruction per four cycles.
module tiny_cpu_mc
  import tiny_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG = 4,
  localparam int RA_W = $clog2(NREG),
  localparam int INSTR_W = 4 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  res,
  output logic               res_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic               illegal
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREG];
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_c;
  logic               alu_z;
  logic [3:0]         op;
  logic [RA_W-1:0]    rd;
  logic [RA_W-1:0]    rs;

  assign op  = ir[INSTR_W-1 -: 4];
  assign rd  = ir[2*RA_W-1 -: RA_W];
  assign rs  = ir[RA_W-1:0];
  assign imm = DATA_W'(ir[2*RA_W-1:0]);

  assign instr_ready = (state == S_IDLE) && !rst;

  tiny_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op(op),
    .a (op_a),
    .b (op_b),
    .y (alu_y),
    .c (alu_c),
    .z (alu_z)
  );

  // Sequencer, register file and all registered outputs; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          op_a  <= regs[rd];
          op_b  <= regs[rs];
          state <= S_WB;
        end
        S_WB: begin
          state <= S_IDLE;
          case (op)
            OP_NOP: ;
            OP_LDI: regs[0] <= imm;
            OP_MOV: regs[rd] <= op_b;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
              regs[rd] <= alu_y;
              flag_c   <= alu_c;
              flag_z   <= alu_z;
            end
            OP_OUT: begin
              res       <= op_b;
              res_valid <= 1'b1;
            end
            default: illegal <= 1'b1;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_cpu_mc.sv
// Self-checking bench for tiny_cpu_mc: directed scenarios plus random instructions against a behavioural model.
module tb_tiny_cpu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] res;
  logic       res_valid;
  logic       flag_z;
  logic       flag_c;
  logic       illegal;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  // Behavioural model state: plain integers, updated instruction by instruction
  int m_regs [4];
  int m_c;
  int m_z;
  int m_res;

  int         accepts;
  logic [7:0] ready_hist;
  logic [7:0] rnd;

  always #5 clk = ~clk;

  tiny_cpu_mc #(
    .DATA_W(8),
    .NREG  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .res        (res),
    .res_valid  (res_valid),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .illegal    (illegal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_c   = 0;
    m_z   = 0;
    m_res = 0;
  endtask

  // Architectural effect of one instruction, computed with integer arithmetic
  task automatic model_step(input logic [7:0] ins, output int ev, output int ei);
    int opc;
    int d;
    int s;
    int a;
    int b;
    int r;
    int alu;
    opc = int'(ins[7:4]);
    d   = int'(ins[3:2]);
    s   = int'(ins[1:0]);
    a   = m_regs[d];
    b   = m_regs[s];
    r   = 0;
    alu = 0;
    ev  = 0;
    ei  = 0;
    case (opc)
      0: ;
      1: m_regs[0] = int'(ins[3:0]);
      2: m_regs[d] = b;
      3: begin r = a + b; m_c = (r > 255) ? 1 : 0; r = r % 256; alu = 1; end
      4: begin m_c = (b > a) ? 1 : 0; r = (a - b + 256) % 256; alu = 1; end
      5: begin r = a & b; m_c = 0; alu = 1; end
      6: begin r = a | b; m_c = 0; alu = 1; end
      7: begin r = a ^ b; m_c = 0; alu = 1; end
      8: begin m_c = (a >= 128) ? 1 : 0; r = (a * 2) % 256; alu = 1; end
      9: begin m_c = a % 2; r = a / 2; alu = 1; end
      10: begin m_res = b; ev = 1; end
      default: ei = 1;
    endcase
    if (alu != 0) begin
      m_regs[d] = r;
      m_z = (r == 0) ? 1 : 0;
    end
  endtask

  // Issue one instruction from IDLE and follow it through DECODE, EXEC, WB and back to IDLE
  task automatic applyStimulus(input logic [7:0] ins, input string tag);
    int ev;
    int ei;
    checkOutput({tag, "_ready_idle"}, 32'(instr_ready), 1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = ~ins;
    for (int k = 0; k < 3; k++) begin
      checkOutput({tag, "_busy_ready"}, 32'(instr_ready), 0);
      checkOutput({tag, "_busy_res_valid"}, 32'(res_valid), 0);
      checkOutput({tag, "_busy_illegal"}, 32'(illegal), 0);
      @(posedge clk);
      #1;
    end
    model_step(ins, ev, ei);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), ev);
    checkOutput({tag, "_illegal"}, 32'(illegal), ei);
    checkOutput({tag, "_res"}, 32'(res), m_res);
    checkOutput({tag, "_flag_z"}, 32'(flag_z), m_z);
    checkOutput({tag, "_flag_c"}, 32'(flag_c), m_c);
    checkOutput({tag, "_ready_back"}, 32'(instr_ready), 1);
  endtask

  initial begin
    int ev;
    int ei;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(instr_ready), 0);
    checkOutput("rst_res", 32'(res), 0);
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_illegal", 32'(illegal), 0);
    checkOutput("rst_flags", {30'd0, flag_z, flag_c}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(instr_ready), 1);
    @(posedge clk);
    #1;

    // LDI 0xF then OUT r0
    applyStimulus(8'h1F, "ldi_f");
    applyStimulus(8'hA0, "out_r0");
    checkOutput("ldi_out_value", 32'(res), 32'h0F);

    // Shift left four times then double via ADD r0,r0
    for (int i = 0; i < 4; i++) applyStimulus(8'h80, "shl_r0");
    checkOutput("shl_carry", 32'(flag_c), 0);
    applyStimulus(8'h30, "add_r0r0");
    checkOutput("add_carry", 32'(flag_c), 1);
    checkOutput("add_zero", 32'(flag_z), 0);
    applyStimulus(8'hA0, "out_add");
    checkOutput("add_value", 32'(res), 32'hE0);

    // SUB r0,r0, MOV r1,r0, LDI 1, SUB r1,r0 gives borrow
    applyStimulus(8'h40, "sub_r0r0");
    checkOutput("sub_self_zero", 32'(flag_z), 1);
    checkOutput("sub_self_carry", 32'(flag_c), 0);
    applyStimulus(8'h24, "mov_r1r0");
    applyStimulus(8'h11, "ldi_1");
    applyStimulus(8'h44, "sub_r1r0");
    checkOutput("sub_borrow", 32'(flag_c), 1);
    applyStimulus(8'hA1, "out_r1");
    checkOutput("sub_value", 32'(res), 32'hFF);

    // Undefined opcode leaves architectural state alone
    applyStimulus(8'hC0, "illegal_c0");
    checkOutput("illegal_res_kept", 32'(res), 32'hFF);
    for (int i = 0; i < 4; i++) applyStimulus({6'b1010_00, 2'(i)}, "out_after_illegal");

    // instr_valid held for eight cycles: two accepts, three not-ready cycles between
    instr       = 8'hA1;
    instr_valid = 1'b1;
    accepts     = 0;
    ready_hist  = '0;
    for (int k = 0; k < 8; k++) begin
      ready_hist[k] = instr_ready;
      if (instr_ready) begin
        accepts++;
        model_step(8'hA1, ev, ei);
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    checkOutput("hold_accepts", 32'(accepts), 2);
    checkOutput("hold_ready_pattern", 32'(ready_hist), 32'h11);
    checkOutput("hold_res_valid", 32'(res_valid), 1);
    checkOutput("hold_res", 32'(res), m_res);
    @(posedge clk);
    #1;

    // Reset during EXEC of an OUT aborts it
    checkOutput("abort_pre_res", 32'(res), 32'hFF);
    instr       = 8'hA1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_res", 32'(res), 0);
    checkOutput("abort_res_valid", 32'(res_valid), 0);
    checkOutput("abort_ready", 32'(instr_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("abort_res_valid_hold", 32'(res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checkOutput("abort_release_ready", 32'(instr_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_res_valid", 32'(res_valid), 0);
    end
    applyStimulus(8'hA1, "out_r1_after_rst");

    // Random instruction stream, with periodic LDIs to seed values
    for (int n = 0; n < 60; n++) begin
      rnd = 8'($urandom);
      if (n % 5 == 0) rnd = {4'h1, 4'($urandom_range(0, 15))};
      applyStimulus(rnd, "rand");
    end
    for (int i = 0; i < 4; i++) applyStimulus({6'b1010_00, 2'(i)}, "rand_out");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_mc.md
TINY_CPU_MC -- requirements
Module: tiny_cpu_mc

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 8, giving the datapath and register width.
REQ-002 The block SHALL have the parameter NREG, default 4, giving the register count: a power of two, 2..16; RA_W = log2(NREG).
REQ-003 The block SHALL have the derived parameter INSTR_W = 4 + 2*RA_W (8 at defaults); 2*RA_W <= DATA_W is required.
REQ-004 The block SHALL have port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst: input, 1 bit, asynchronous, active-high reset.
REQ-006 The block SHALL have port instr: input, INSTR_W bits; fields are op[INSTR_W-1:INSTR_W-4], rd[2*RA_W-1:RA_W] and rs[RA_W-1:0].
REQ-007 The block SHALL have port instr_valid: input, 1 bit, meaning the host offers instr.
REQ-008 The block SHALL have port instr_ready: output, 1 bit, meaning the CPU can accept an instruction.
REQ-009 The block SHALL have port res: output, DATA_W bits, the last OUT value, held between OUTs.
REQ-010 The block SHALL have port res_valid: output, 1 bit, a one-cycle pulse when res updates.
REQ-011 The block SHALL have ports flag_z and flag_c: outputs, 1 bit each, the zero and carry/borrow flags.
REQ-012 The block SHALL have port illegal: output, 1 bit, a one-cycle pulse on an undefined opcode.

Function
REQ-013 The control SHALL be a four-state FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE, one cycle per state.
REQ-014 instr_ready SHALL be 1 only in IDLE and 0 while rst is high.
REQ-015 Accept SHALL occur on instr_valid && instr_ready, latching instr and moving to DECODE.
REQ-016 instr_valid outside IDLE SHALL be ignored; the host holds the instruction; sustained throughput is 1 instruction per 4 cycles.
REQ-017 Opcode 0000 SHALL be NOP: no state change.
REQ-018 Opcode 0001 SHALL be LDI: r0 <= zero-extended {rd,rs}; flags unchanged.
REQ-019 Opcode 0010 SHALL be MOV: rd <= rs; flags unchanged.
REQ-020 Opcode 0011 SHALL be ADD: rd <= rd+rs mod 2^DATA_W; C = carry out.
REQ-021 Opcode 0100 SHALL be SUB: rd <= rd-rs mod 2^DATA_W; C = 1 iff rs > rd (borrow).
REQ-022 Opcodes 0101, 0110 and 0111 SHALL be AND, OR and XOR: rd <= rd op rs; C cleared.
REQ-023 Opcode 1000 SHALL be SHL: rd <= rd<<1; C = old MSB.
REQ-024 Opcode 1001 SHALL be SHR (logical): rd <= rd>>1; C = old LSB.
REQ-025 Opcode 1010 SHALL be OUT: res <= rs; res_valid pulses in the WB cycle; flags unchanged.
REQ-026 Opcodes 1011 and 11xx SHALL be illegal: illegal pulses in the WB cycle; registers, flags and res unchanged.
REQ-027 Z SHALL equal (result == 0) for ADD, SUB, AND, OR, XOR, SHL and SHR only.
REQ-028 Operands SHALL be read in EXEC; register and flag writeback SHALL occur at the WB edge.
REQ-029 Register writes SHALL be visible to the next accepted instruction.
REQ-030 rd == rs SHALL be legal and SHALL use the old value for both operands.
REQ-031 res_valid and illegal SHALL never both be high.

Reset
REQ-032 While rst is high: state = IDLE; all registers, res, flag_z, flag_c, res_valid and illegal = 0.
REQ-033 Reset asserted mid-instruction SHALL abort that instruction: no writeback and no res_valid.
REQ-034 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 The opcode localparams and the FSM state encoding SHALL reside in the shared package tiny_cpu_pkg.
REQ-036 The combinational ALU (result, C, Z) SHALL be the sub-module tiny_alu, parametrised by DATA_W.
REQ-037 The register file SHALL be an NREG x DATA_W array inside tiny_cpu_mc.

Verification (defaults: DATA_W=8, NREG=4)
REQ-038 Bench SHALL cover: LDI 0001_1111, then OUT r0 1010_0000 -> res=0x0F, res_valid high exactly one cycle, 4 cycles after the OUT accept.
REQ-039 Bench SHALL cover: LDI 0xF, SHL r0 x4 (1000_0000) -> r0=0xF0, C=0; ADD r0,r0 (0011_0000) -> r0=0xE0, C=1, Z=0.
REQ-040 Bench SHALL cover: SUB r0,r0 (0100_0000) -> r0=0x00, Z=1, C=0; then MOV r1,r0 and SUB r1 minus LDI-loaded 0x01 -> 0xFF, C=1.
REQ-041 Bench SHALL cover: instr 1100_0000 -> illegal pulses once; registers, flags and res unchanged; res_valid stays 0.
REQ-042 Bench SHALL cover: instr_valid held high for 8 cycles with one instruction -> exactly two accepts; instr_ready low 3 cycles between them.
REQ-043 Bench SHALL cover: rst pulsed during EXEC of OUT -> no res_valid; res=0; instr_ready=1 in the first cycle after release.
